// File: rtl/countdown_timer_pkg.sv
// Shared types, field limits and time-field helpers for the countdown timer.
// Count is packed {hour, minute, second} plus hundredths, matching the stopwatch format.
package countdown_timer_pkg;

    localparam int FIELD_W = 6;
    localparam int HUND_W  = 8;
    localparam int EPOCH_W = 3 * FIELD_W;

    localparam logic [FIELD_W-1:0] MAX_HOUR       = 6'd23;
    localparam logic [FIELD_W-1:0] MAX_MIN_SEC    = 6'd59;
    localparam logic [HUND_W-1:0]  MAX_HUNDREDTHS = 8'd99;

    typedef enum logic [1:0] {
        IDLE,
        PAUSED,
        RUNNING,
        EXPIRED
    } timer_state_e;

    typedef struct packed {
        logic [FIELD_W-1:0] hour;
        logic [FIELD_W-1:0] minute;
        logic [FIELD_W-1:0] second;
        logic [HUND_W-1:0]  hund;
    } count_t;

    function automatic count_t clamp_count(input logic [EPOCH_W-1:0] ep, input logic [HUND_W-1:0] hs);
        count_t c;
        c.hour   = (ep[17:12] > MAX_HOUR)    ? MAX_HOUR    : ep[17:12];
        c.minute = (ep[11:6]  > MAX_MIN_SEC) ? MAX_MIN_SEC : ep[11:6];
        c.second = (ep[5:0]   > MAX_MIN_SEC) ? MAX_MIN_SEC : ep[5:0];
        c.hund   = (hs > MAX_HUNDREDTHS)     ? MAX_HUNDREDTHS : hs;
        return c;
    endfunction

    // Borrow chain; only ever applied to a nonzero count.
    function automatic count_t dec_count(input count_t c);
        count_t r;
        r = c;
        if (c.hund != '0) begin
            r.hund = c.hund - 8'd1;
        end else begin
            r.hund = MAX_HUNDREDTHS;
            if (c.second != '0) begin
                r.second = c.second - 6'd1;
            end else begin
                r.second = MAX_MIN_SEC;
                if (c.minute != '0) begin
                    r.minute = c.minute - 6'd1;
                end else begin
                    r.minute = MAX_MIN_SEC;
                    r.hour   = c.hour - 6'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic is_zero(input count_t c);
        return c == '0;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the mode/keypad controller and the countdown timer.
interface countdown_timer_if;
    import countdown_timer_pkg::*;

    logic               load;
    logic [EPOCH_W-1:0] preset_epoch;
    logic [HUND_W-1:0]  preset_m_epoch;
    logic               run;
    logic               clear;
    logic [EPOCH_W-1:0] epoch;
    logic [HUND_W-1:0]  m_epoch;
    logic               expired;
    logic               done_pulse;

    modport master (
        output load, preset_epoch, preset_m_epoch, run, clear,
        input  epoch, m_epoch, expired, done_pulse
    );

    modport slave (
        input  load, preset_epoch, preset_m_epoch, run, clear,
        output epoch, m_epoch, expired, done_pulse
    );

endinterface

// File: rtl/countdown_timer_tick_divider.sv
// Clock-enable generator: one-cycle tick every CLK_HZ/TICK_HZ enabled cycles.
// Down-counter; the phase is held while enable is low and restarts on sync_clear.
module tick_divider #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic sync_clear,
    output logic tick
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= LAST;
        end else if (sync_clear) begin
            cnt <= LAST;
        end else if (enable) begin
            cnt <= tick ? LAST : cnt - 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: loads a clamped preset, decrements at TICK_HZ while run is high,
// and flags expiry at 00:00:00.00.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | count is zero, run ignored
// PAUSED   | count nonzero and held, waiting for run
// RUNNING  | decrementing on each divider tick
// EXPIRED  | reached zero from a tick; held until clear/load
module countdown_timer #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic             clock,
    input  logic             reset,
    countdown_timer_if.slave bus
);
    import countdown_timer_pkg::*;

    timer_state_e state;
    count_t       count_q;
    count_t       count_dec;
    count_t       count_load;
    logic         expired_q;
    logic         done_q;
    logic         tick;
    logic         div_enable;

    // Divider only advances while actually counting, so a pause keeps its phase.
    assign div_enable = (state == RUNNING) && bus.run;
    assign count_dec  = dec_count(count_q);
    assign count_load = clamp_count(bus.preset_epoch, bus.preset_m_epoch);

    tick_divider #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_divider (
        .clock      (clock),
        .reset      (reset),
        .enable     (div_enable),
        .sync_clear (bus.clear | bus.load),
        .tick       (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count_q   <= '0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.clear) begin
                state     <= IDLE;
                count_q   <= '0;
                expired_q <= 1'b0;
            end else if (bus.load) begin
                count_q   <= count_load;
                state     <= is_zero(count_load) ? IDLE : PAUSED;
                expired_q <= 1'b0;
            end else begin
                case (state)
                    PAUSED: begin
                        if (bus.run) state <= RUNNING;
                    end
                    RUNNING: begin
                        if (!bus.run) begin
                            state <= PAUSED;
                        end else if (tick) begin
                            count_q <= count_dec;
                            if (is_zero(count_dec)) begin
                                state     <= EXPIRED;
                                expired_q <= 1'b1;
                                done_q    <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.epoch      = {count_q.hour, count_q.minute, count_q.second};
    assign bus.m_epoch    = count_q.hund;
    assign bus.expired    = expired_q;
    assign bus.done_pulse = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: clamp vector table, directed corner sequences and
// randomized traffic against a total-hundredths reference model.
module tb_countdown_timer;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    localparam int M_IDLE    = 0;
    localparam int M_PAUSED  = 1;
    localparam int M_RUNNING = 2;
    localparam int M_EXPIRED = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    countdown_timer_if bus();

    countdown_timer #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    int m_total;
    int m_mode;
    int m_phase;
    logic m_exp;
    logic m_done;

    typedef struct {
        logic [17:0] ep;
        logic [7:0]  hs;
        logic [17:0] exp_ep;
        logic [7:0]  exp_hs;
    } clamp_vec_t;

    clamp_vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_total(input logic [17:0] ep, input logic [7:0] hs);
        int h, m, s, c;
        h = int'(ep[17:12]);
        m = int'(ep[11:6]);
        s = int'(ep[5:0]);
        c = int'(hs);
        if (h > 23) h = 23;
        if (m > 59) m = 59;
        if (s > 59) s = 59;
        if (c > 99) c = 99;
        return ((h * 60 + m) * 60 + s) * 100 + c;
    endfunction

    function automatic logic [27:0] model_out();
        int t;
        t = m_total;
        return {6'(t / 360000), 6'((t / 6000) % 60), 6'((t / 100) % 60), 8'(t % 100), m_exp, m_done};
    endfunction

    task automatic model_reset();
        m_total = 0;
        m_mode  = M_IDLE;
        m_phase = 0;
        m_exp   = 1'b0;
        m_done  = 1'b0;
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (bus.clear) begin
            m_total = 0;
            m_mode  = M_IDLE;
            m_phase = 0;
            m_exp   = 1'b0;
        end else if (bus.load) begin
            m_total = clamp_total(bus.preset_epoch, bus.preset_m_epoch);
            m_mode  = (m_total != 0) ? M_PAUSED : M_IDLE;
            m_phase = 0;
            m_exp   = 1'b0;
        end else if (m_mode == M_PAUSED) begin
            if (bus.run) m_mode = M_RUNNING;
        end else if (m_mode == M_RUNNING) begin
            if (!bus.run) begin
                m_mode = M_PAUSED;
            end else begin
                m_phase++;
                if (m_phase == DIV) begin
                    m_phase = 0;
                    m_total--;
                    if (m_total == 0) begin
                        m_mode = M_EXPIRED;
                        m_exp  = 1'b1;
                        m_done = 1'b1;
                    end
                end
            end
        end
    endtask

    function automatic logic [27:0] dut_out();
        return {bus.epoch, bus.m_epoch, bus.expired, bus.done_pulse};
    endfunction

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check("cycle_outputs", 64'(dut_out()), 64'(model_out()));
    endtask

    task automatic drive(input logic ld, input logic [17:0] ep, input logic [7:0] hs,
                         input logic rn, input logic clr);
        bus.load           = ld;
        bus.preset_epoch   = ep;
        bus.preset_m_epoch = hs;
        bus.run            = rn;
        bus.clear          = clr;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic saw_done;
        logic [7:0] hs_before;

        vecs[0] = '{{6'd30, 6'd63, 6'd63}, 8'd150, {6'd23, 6'd59, 6'd59}, 8'd99};
        vecs[1] = '{{6'd12, 6'd34, 6'd56}, 8'd78,  {6'd12, 6'd34, 6'd56}, 8'd78};
        vecs[2] = '{{6'd24, 6'd60, 6'd60}, 8'd100, {6'd23, 6'd59, 6'd59}, 8'd99};
        vecs[3] = '{{6'd23, 6'd59, 6'd59}, 8'd99,  {6'd23, 6'd59, 6'd59}, 8'd99};
        vecs[4] = '{{6'd0,  6'd0,  6'd0},  8'd0,   {6'd0,  6'd0,  6'd0},  8'd0};
        vecs[5] = '{{6'd5,  6'd60, 6'd3},  8'd99,  {6'd5,  6'd59, 6'd3},  8'd99};
        vecs[6] = '{{6'd0,  6'd0,  6'd61}, 8'd255, {6'd0,  6'd0,  6'd59}, 8'd99};

        drive(1'b0, '0, '0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", 64'(dut_out()), 64'(0));
        reset = 1'b1;

        // Clamp table
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, vecs[i].ep, vecs[i].hs, 1'b0, 1'b0);
            cycle();
            check("clamp_epoch", 64'(bus.epoch), 64'(vecs[i].exp_ep));
            check("clamp_hund", 64'(bus.m_epoch), 64'(vecs[i].exp_hs));
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        cycle();

        // 00:00:01.02 runs down to expiry
        drive(1'b1, {6'd0, 6'd0, 6'd1}, 8'd2, 1'b1, 1'b0);
        cycle();
        bus.load = 1'b0;
        n = 0;
        for (int i = 1; i <= 1100 && n == 0; i++) begin
            cycle();
            if (bus.done_pulse) n = i;
        end
        check("expiry_latency", 64'(n), 64'(1 + 102 * DIV));
        check("expiry_count", 64'({bus.epoch, bus.m_epoch}), 64'(0));
        cycle();
        check("done_width", 64'(bus.done_pulse), 64'(0));
        check("expired_level", 64'(bus.expired), 64'(1));
        repeat (20) cycle();
        check("expired_hold", 64'({bus.epoch, bus.m_epoch, bus.expired}), 64'(1));

        // Full borrow chain
        drive(1'b1, {6'd1, 6'd0, 6'd0}, 8'd0, 1'b1, 1'b0);
        cycle();
        bus.load = 1'b0;
        repeat (DIV) cycle();
        check("pre_borrow", 64'({bus.epoch, bus.m_epoch}), 64'({6'd1, 6'd0, 6'd0, 8'd0}));
        cycle();
        check("borrow_chain", 64'({bus.epoch, bus.m_epoch}), 64'({6'd0, 6'd59, 6'd59, 8'd99}));

        // All-zero load: run ignored
        drive(1'b1, '0, '0, 1'b1, 1'b0);
        cycle();
        bus.load = 1'b0;
        saw_done = 1'b0;
        repeat (30) begin
            cycle();
            if (bus.done_pulse) saw_done = 1'b1;
        end
        check("zero_load_no_done", 64'(saw_done), 64'(0));
        check("zero_load_idle", 64'({bus.epoch, bus.m_epoch, bus.expired}), 64'(0));

        // Pause with divider phase preserved
        drive(1'b1, {6'd0, 6'd0, 6'd10}, 8'd0, 1'b1, 1'b0);
        cycle();
        bus.load = 1'b0;
        repeat (26) cycle();
        check("pre_pause", 64'({bus.epoch, bus.m_epoch}), 64'({6'd0, 6'd0, 6'd9, 8'd98}));
        bus.run = 1'b0;
        repeat (51) cycle();
        check("paused_frozen", 64'({bus.epoch, bus.m_epoch}), 64'({6'd0, 6'd0, 6'd9, 8'd98}));
        bus.run = 1'b1;
        hs_before = bus.m_epoch;
        n = 0;
        for (int i = 1; i <= 3 * DIV && n == 0; i++) begin
            cycle();
            if (bus.m_epoch != hs_before) n = i;
        end
        check("resume_phase", 64'(n), 64'(DIV - 5 + 1));
        check("resume_value", 64'(bus.m_epoch), 64'(97));

        // Load on the tick edge wins
        drive(1'b1, {6'd0, 6'd0, 6'd5}, 8'd0, 1'b1, 1'b0);
        cycle();
        bus.load = 1'b0;
        repeat (DIV) cycle();
        drive(1'b1, {6'd0, 6'd0, 6'd7}, 8'd0, 1'b1, 1'b0);
        cycle();
        check("load_beats_tick", 64'({bus.epoch, bus.m_epoch}), 64'({6'd0, 6'd0, 6'd7, 8'd0}));
        bus.load = 1'b0;
        repeat (5) cycle();

        // Clear beats load
        drive(1'b1, {6'd0, 6'd0, 6'd9}, 8'd0, 1'b1, 1'b1);
        cycle();
        check("clear_beats_load", 64'({bus.epoch, bus.m_epoch, bus.expired}), 64'(0));
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (20) cycle();
        check("idle_after_clear", 64'({bus.epoch, bus.m_epoch, bus.done_pulse}), 64'(0));

        // Async reset mid-count at 00:00:00.05
        drive(1'b1, '0, 8'd10, 1'b1, 1'b0);
        cycle();
        bus.load = 1'b0;
        repeat (1 + 5 * DIV) cycle();
        check("pre_reset_count", 64'(bus.m_epoch), 64'(5));
        repeat (3) cycle();
        #2 reset = 1'b0;
        #1;
        check("async_reset", 64'(dut_out()), 64'(0));
        model_reset();
        @(posedge clock);
        #1;
        check("reset_held", 64'(dut_out()), 64'(0));
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (100) begin
            cycle();
            if (bus.done_pulse) saw_done = 1'b1;
        end
        check("no_done_after_reset", 64'(saw_done), 64'(0));

        // Randomized traffic against the model
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            bus.load  = ($urandom_range(0, 39) == 0);
            bus.clear = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 24) == 0) bus.run = ~bus.run;
            if ($urandom_range(0, 1) == 0) begin
                bus.preset_epoch   = {6'd0, 6'd0, 6'($urandom_range(0, 2))};
                bus.preset_m_epoch = 8'($urandom_range(0, 120));
            end else begin
                bus.preset_epoch   = 18'($urandom);
                bus.preset_m_epoch = 8'($urandom);
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
